poseidon_input_packer: RTL

- Upstream stage of the Poseidon top-level wrapper.
- Converts a 64-bit host stream into the wrapper's 256-bit input word.
- Each 255-bit field element arrives as 4 beats, least-significant beat first.
- Output word carries the message-end flag in bit 255 and the element in bits 254:0, ready for the wrapper's input port.

---
 rtl/poseidon_input_packer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/poseidon_input_packer.sv
// Purpose : packs four 64-bit host beats (LS beat first) into one 256-bit word {last, element[254:0]}.
// Latency : packed word is valid the cycle after the final beat of an element is accepted.
// Backpressure: input is always ready while filling; on the closing beat it is ready only if the
//               output register is empty or draining this cycle.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset, released synchronously
//   io_input_*          host beat stream (valid/ready), io_input_last marks end of message
//   io_output_*         packed word stream (valid/ready) towards the wrapper
//   io_error            sticky protocol error, cleared by io_clear_error
//   io_range_err_count  saturating count of non-canonical elements (only when
//                       POSEIDON_PACKER_RANGE_CHECK_EN is defined)
//
// Optional feature macro: POSEIDON_PACKER_RANGE_CHECK_EN
//   defined   -> element bit 255 set on a full element raises io_error and bumps io_range_err_count
//   undefined -> element bit 255 is silently dropped, no counter port
module poseidon_input_packer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_input_valid,
    output logic                 io_input_ready,
    input  logic                 io_input_last,
    input  logic [IN_WIDTH-1:0]  io_input_payload,
    output logic                 io_output_valid,
    input  logic                 io_output_ready,
    output logic [OUT_WIDTH-1:0] io_output_payload,
    output logic                 io_error,
`ifdef POSEIDON_PACKER_RANGE_CHECK_EN
    output logic [15:0]          io_range_err_count,
`endif
    input  logic                 io_clear_error
);

    localparam int BEATS = OUT_WIDTH / IN_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {
        FILL,
        COMPLETE
    } state_t;

    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [OUT_WIDTH-1:0] asm_q;
    state_t               state;
    logic                 accept;
    logic                 load;
    logic                 err_set;
    logic                 range_hit;
    logic [OUT_WIDTH-1:0] word;

    // Beat position is the FSM state: the closing slot is COMPLETE, all others FILL.
    always_comb begin
        state          = (cnt_q == LAST_BEAT) ? COMPLETE : FILL;
        io_input_ready = 1'b1;
        // Any beat that would emit a word (closing beat or early last) needs the
        // output register free, or freeing this cycle.
        if (state == COMPLETE || io_input_last) begin
            io_input_ready = !io_output_valid || io_output_ready;
        end
        accept = io_input_valid && io_input_ready;
        load   = accept && (state == COMPLETE || io_input_last);

        // Word as it would look with the current beat merged in: lower slices from
        // the assembly register, current slice from the bus, upper slices zero.
        // The zero fill is what an early last emits.
        word = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (CW'(i) < cnt_q) begin
                word[i*IN_WIDTH +: IN_WIDTH] = asm_q[i*IN_WIDTH +: IN_WIDTH];
            end else if (CW'(i) == cnt_q) begin
                word[i*IN_WIDTH +: IN_WIDTH] = io_input_payload;
            end
        end

`ifdef POSEIDON_PACKER_RANGE_CHECK_EN
        range_hit = accept && (state == COMPLETE) && io_input_payload[IN_WIDTH-1];
`else
        range_hit = 1'b0;
`endif
        // Early last: a word goes out before the closing slot was reached.
        err_set = (load && state == FILL) || range_hit;

        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q             <= '0;
            asm_q             <= '0;
            io_output_valid   <= 1'b0;
            io_output_payload <= '0;
            io_error          <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                asm_q <= '0;
            end else if (accept) begin
                asm_q <= word;
            end

            if (load) begin
                // Raw bit 255 of the element is replaced by the message-end flag.
                io_output_payload <= {io_input_last, word[OUT_WIDTH-2:0]};
                io_output_valid   <= 1'b1;
            end else if (io_output_ready) begin
                io_output_valid   <= 1'b0;
            end

            // A fresh error beats a simultaneous clear.
            if (err_set) begin
                io_error <= 1'b1;
            end else if (io_clear_error) begin
                io_error <= 1'b0;
            end
        end
    end

`ifdef POSEIDON_PACKER_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_range_err_count <= '0;
        end else if (io_clear_error) begin
            io_range_err_count <= range_hit ? 16'd1 : 16'd0;
        end else if (range_hit && io_range_err_count != 16'hFFFF) begin
            io_range_err_count <= io_range_err_count + 16'd1;
        end
    end
`endif

endmodule
